// File: rtl/regfile_wb_bypass.sv
// 32x32 register file with writeback bypass and a load-pending
// scoreboard that raises stall_o on load-use hazards.
module regfile_wb_bypass #(
  parameter logic CLR_ON_RST = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic        wb_rd_wren_i,
  input  logic [31:0] wb_data_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic        rs1_use_i,
  input  logic        rs2_use_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        ld_issue_i,
  input  logic [4:0]  ld_rd_addr_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [5:0]  pend_cnt_o
);

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic [31:0] pend_q, pend_d;
  logic [5:0]  cnt_q, cnt_d;

  logic        wb_hit;
  logic [31:0] wb_clr;
  logic [31:0] pend_eff;
  logic [31:0] ld_set;

  assign wb_hit = wb_rd_wren_i && (wb_rd_addr_i != 5'd0);

  always_comb begin
    rf_d = rf_q;
    if (wb_hit) rf_d[wb_rd_addr_i] = wb_data_i;
    rf_d[0] = '0;
  end

  always_comb begin
    rs1_data_o = rf_q[rs1_addr_i];
    if (wb_hit && (wb_rd_addr_i == rs1_addr_i)) rs1_data_o = wb_data_i;
    if (rs1_addr_i == 5'd0) rs1_data_o = '0;
    rs2_data_o = rf_q[rs2_addr_i];
    if (wb_hit && (wb_rd_addr_i == rs2_addr_i)) rs2_data_o = wb_data_i;
    if (rs2_addr_i == 5'd0) rs2_data_o = '0;
  end

  // A register being written back this cycle is covered by the bypass.
  always_comb begin
    wb_clr   = wb_rd_wren_i ? (32'd1 << wb_rd_addr_i) : 32'd0;
    pend_eff = pend_q & ~wb_clr;
    stall_o  = !flush_i &&
               ((rs1_use_i && pend_eff[rs1_addr_i]) ||
                (rs2_use_i && pend_eff[rs2_addr_i]));
  end

  always_comb begin
    ld_set = '0;
    if (ld_issue_i && !stall_o && !flush_i && (ld_rd_addr_i != 5'd0))
      ld_set = 32'd1 << ld_rd_addr_i;
    pend_d = flush_i ? 32'd0 : (pend_eff | ld_set);
    pend_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < 32; i++) cnt_d = cnt_d + 6'(pend_d[i]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q <= '0;
      cnt_q  <= '0;
      if (CLR_ON_RST) begin
        for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end
    end else begin
      rf_q   <= rf_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt_o = cnt_q;

endmodule

// File: doc/regfile_wb_bypass.md
REGFILE_WB_BYPASS -- requirements
Module: regfile_wb_bypass

Interface
REQ-001 SHALL have parameter CLR_ON_RST, default 1, meaning: when 1, all 31 writable registers clear to 0 on reset; when 0, only scoreboard/state reset.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port wb_rd_addr_i  input  5  writeback destination register.
REQ-005 SHALL have port wb_rd_wren_i  input  1  writeback register write enable.
REQ-006 SHALL have port wb_data_i  input  32  writeback data (selected ld/alu/pc+4 result).
REQ-007 SHALL have ports rs1_addr_i, rs2_addr_i  input  5 each  decode-stage source addresses.
REQ-008 SHALL have ports rs1_use_i, rs2_use_i  input  1 each  source operand actually consumed.
REQ-009 SHALL have ports rs1_data_o, rs2_data_o  output  32 each  operand read data.
REQ-010 SHALL have port ld_issue_i  input  1  decode stage issuing a load this cycle.
REQ-011 SHALL have port ld_rd_addr_i  input  5  destination of the issuing load.
REQ-012 SHALL have port flush_i  input  1  pipeline flush; cancels all in-flight loads.
REQ-013 SHALL have port stall_o  output  1  load-use hazard; decode must hold.
REQ-014 SHALL have port pend_cnt_o  output  6  number of registers with a pending load.

Function
REQ-015 SHALL hold 32 x 32-bit registers; x0 reads 0 always, writes to x0 discarded.
REQ-016 SHALL write wb_data_i to register wb_rd_addr_i on clock edge when wb_rd_wren_i=1 and address nonzero.
REQ-017 SHALL read combinationally (zero-latency): rsN_data_o = wb_data_i if wb_rd_wren_i=1, wb_rd_addr_i=rsN_addr_i, address nonzero; else stored value.
REQ-018 SHALL keep a 32-bit pending scoreboard; bit 0 permanently 0.
REQ-019 SHALL set pending[ld_rd_addr_i] on edge when ld_issue_i=1, stall_o=0, flush_i=0, ld_rd_addr_i nonzero.
REQ-020 SHALL ignore ld_issue_i while stall_o=1 or flush_i=1.
REQ-021 SHALL clear pending[wb_rd_addr_i] on edge when wb_rd_wren_i=1.
REQ-022 SHALL, on simultaneous set and clear of the same address, leave bit set (new load wins).
REQ-023 SHALL, on flush_i=1, clear all pending bits next edge regardless of other inputs.
REQ-024 SHALL assert stall_o combinationally when (rs1_use_i and pending[rs1_addr_i]) or (rs2_use_i and pending[rs2_addr_i]), excluding any address being cleared by writeback that cycle (bypass covers it).
REQ-025 SHALL force stall_o=0 while flush_i=1.
REQ-026 SHALL drive pend_cnt_o as registered population count of pending bits (0..31), updated same edge as scoreboard.
REQ-027 SHALL perform writeback register update even while stall_o=1 or flush_i=1.

Reset
REQ-028 SHALL, on rising edge with rst_ni=0, clear all pending bits and pend_cnt_o to 0; clear registers x1..x31 to 0 when CLR_ON_RST=1.
REQ-029 SHALL give reset priority over writeback, load issue and flush in the same cycle.
REQ-030 SHALL drive stall_o=0 and rsN_data_o=0 (CLR_ON_RST=1, no bypass active) in the cycle after reset.
REQ-031 SHALL discard a pending load cancelled by reset mid-flight; its later writeback still updates the register and leaves scoreboard at 0.

Verification
REQ-032 Write x5=0xDEADBEEF, next cycle rs1_addr_i=5 -> rs1_data_o=0xDEADBEEF; same-cycle write x6=0x12345678 with rs2_addr_i=6 -> rs2_data_o=0x12345678 combinationally.
REQ-033 Write x0=0xFFFFFFFF, wb bypass addr 0 -> rs1_data_o=0 both same cycle and next.
REQ-034 Issue load rd=7, next cycle rs1_addr_i=7 rs1_use_i=1 -> stall_o=1, pend_cnt_o=1; writeback x7=0xA5A5A5A5 -> stall_o=0 same cycle, rs1_data_o=0xA5A5A5A5, pend_cnt_o=0 next edge.
REQ-035 Same cycle: writeback x9 and ld_issue_i rd=9 -> pending[9]=1, pend_cnt_o=1; rs2_use_i=0 with rs2_addr_i=9 -> stall_o=0.
REQ-036 Issue loads rd=3,4,8 -> pend_cnt_o=3; flush_i=1 -> pend_cnt_o=0, stall_o=0; ld_issue_i during flush ignored.
REQ-037 Pending rd=10, assert rst_ni=0 one cycle -> pend_cnt_o=0, x10 reads 0; later writeback x10=0x55 -> x10=0x55, pend_cnt_o stays 0.
